ex_stage_pipe: RTL

Registered, handshaked execute stage that replaces the purely combinational execute block. It sits between decode/operand-fetch and memory/writeback. It executes one of four operation classes on each accepted instruction: scalar ALU, lane-serialised vector ALU, scalar bit swap, or vector element swap. It also adds the missing condition unit, which resolves conditional jumps from retained scalar flags.

---
 rtl/ex_stage_pipe_pkg.sv | 55 +++++
 rtl/ex_lane_alu.sv | 62 ++++++
 rtl/ex_stage_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// Shared types for the execute stage: op classes, ALU opcodes,
// jump conditions, flag bit positions and the stage FSM states.
package ex_stage_pipe_pkg;

    typedef enum logic [1:0] {
        CLS_SALU = 2'b00,
        CLS_VALU = 2'b01,
        CLS_SSWP = 2'b10,
        CLS_VSWP = 2'b11
    } op_class_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL1 = 3'b101,
        OP_SHR1 = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        CND_AL = 2'b00,
        CND_EQ = 2'b01,
        CND_NE = 2'b10,
        CND_LT = 2'b11
    } cond_e;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_VBUSY = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    function automatic logic cond_true(input cond_e c,
                                       input logic [3:0] f);
        logic t;
        t = 1'b1;
        unique case (c)
            CND_AL: t = 1'b1;
            CND_EQ: t = f[FLG_Z];
            CND_NE: t = !f[FLG_Z];
            CND_LT: t = f[FLG_N] ^ f[FLG_V];
            default: t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ex_lane_alu.sv
// Combinational W-bit element ALU; used per vector lane and,
// at register width with flags enabled, as the scalar ALU.
import ex_stage_pipe_pkg::*;

module ex_lane_alu #(
    parameter int W        = 8,
    parameter bit FLAGS_EN = 1'b0
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  alu_op_e      op_i,
    output logic [W-1:0] res_o,
    output logic         c_o,
    output logic         v_o
);

    logic [W:0]   sum;
    logic [W-1:0] r;
    logic         c;
    logic         v;

    // Opcode decode; sub reports carry as NOT borrow
    always_comb begin
        sum = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                sum = {1'b0, a_i} + {1'b0, b_i};
                r   = sum[W-1:0];
                c   = sum[W];
                v   = (a_i[W-1] == b_i[W-1]) &&
                      (r[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a_i} - {1'b0, b_i};
                r   = sum[W-1:0];
                c   = ~sum[W];
                v   = (a_i[W-1] != b_i[W-1]) &&
                      (r[W-1] != a_i[W-1]);
            end
            OP_AND: r = a_i & b_i;
            OP_OR:  r = a_i | b_i;
            OP_XOR: r = a_i ^ b_i;
            OP_SHL1: begin
                r = {a_i[W-2:0], 1'b0};
                c = a_i[W-1];
            end
            OP_SHR1: begin
                r = {1'b0, a_i[W-1:1]};
                c = a_i[0];
            end
            OP_PASS: r = b_i;
            default: r = '0;
        endcase
        res_o = r;
        c_o   = FLAGS_EN ? c : 1'b0;
        v_o   = FLAGS_EN ? v : 1'b0;
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered, handshaked execute stage: scalar/vector ALU,
// bit/element swap and condition unit for jumps.
import ex_stage_pipe_pkg::*;

module ex_stage_pipe #(
    parameter int REGI_SIZE  = 16,
    parameter int ELEM_SIZE  = 8,
    parameter int VECT_SIZE  = 8,
    parameter int VECT_LANES = 2,
    parameter int JUMP_BITS  = 10,
    localparam int PW = $clog2(REGI_SIZE),
    localparam int VB = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           op_class_i,
    input  logic [2:0]           alu_op_i,
    input  logic [REGI_SIZE-1:0] int_rsa_i,
    input  logic [REGI_SIZE-1:0] int_rsb_i,
    input  logic [VB-1:0]        vec_rsa_i,
    input  logic [VB-1:0]        vec_rsb_i,
    input  logic [PW-1:0]        pos_a_i,
    input  logic [PW-1:0]        pos_b_i,
    input  logic                 jump_en_i,
    input  logic [1:0]           cond_i,
    input  logic [JUMP_BITS-1:0] jump_addr_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [1:0]           out_class_o,
    output logic [REGI_SIZE-1:0] int_res_o,
    output logic [VB-1:0]        vec_res_o,
    output logic [3:0]           flags_o,
    output logic                 br_taken_o,
    output logic [JUMP_BITS-1:0] br_addr_o
);

    localparam int BEATS = VECT_SIZE / VECT_LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int VW    = $clog2(VECT_SIZE);

    state_e               state_q, state_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic [VB-1:0]        va_q, va_d;
    logic [VB-1:0]        vb_q, vb_d;
    alu_op_e              vop_q, vop_d;
    logic [1:0]           class_q, class_d;
    logic [REGI_SIZE-1:0] int_res_q, int_res_d;
    logic [VB-1:0]        vec_res_q, vec_res_d;
    logic [3:0]           flags_q, flags_d;
    logic                 br_taken_q, br_taken_d;
    logic [JUMP_BITS-1:0] br_addr_q, br_addr_d;

    logic                 accept;
    logic                 cond_hit;
    logic [REGI_SIZE-1:0] s_res;
    logic                 s_c;
    logic                 s_v;
    logic [REGI_SIZE-1:0] sswap;
    logic [VB-1:0]        vswap;
    logic [VW-1:0]        epa;
    logic [VW-1:0]        epb;

    logic [ELEM_SIZE-1:0] lane_a [VECT_LANES];
    logic [ELEM_SIZE-1:0] lane_b [VECT_LANES];
    logic [ELEM_SIZE-1:0] lane_r [VECT_LANES];
    logic [VECT_LANES-1:0] lane_c_unused;
    logic [VECT_LANES-1:0] lane_v_unused;

    assign in_ready_o = (state_q == ST_IDLE) ||
                        (state_q == ST_HOLD && out_ready_i);
    assign accept   = in_valid_i && in_ready_o && !flush_i;
    assign cond_hit = cond_true(cond_e'(cond_i), flags_q);

    ex_lane_alu #(
        .W        (REGI_SIZE),
        .FLAGS_EN (1'b1)
    ) u_salu (
        .a_i   (int_rsa_i),
        .b_i   (int_rsb_i),
        .op_i  (alu_op_e'(alu_op_i)),
        .res_o (s_res),
        .c_o   (s_c),
        .v_o   (s_v)
    );

    for (genvar l = 0; l < VECT_LANES; l++) begin : g_lane
        ex_lane_alu #(
            .W        (ELEM_SIZE),
            .FLAGS_EN (1'b0)
        ) u_lane (
            .a_i   (lane_a[l]),
            .b_i   (lane_b[l]),
            .op_i  (vop_q),
            .res_o (lane_r[l]),
            .c_o   (lane_c_unused[l]),
            .v_o   (lane_v_unused[l])
        );
    end

    // Route the current beat's elements to the lane ALUs
    always_comb begin
        for (int l = 0; l < VECT_LANES; l++) begin
            int idx;
            idx = int'(beat_q) * VECT_LANES + l;
            lane_a[l] = va_q[idx*ELEM_SIZE +: ELEM_SIZE];
            lane_b[l] = vb_q[idx*ELEM_SIZE +: ELEM_SIZE];
        end
    end

    // Bit and element swaps on the incoming operands
    always_comb begin
        epa   = pos_a_i[VW-1:0];
        epb   = pos_b_i[VW-1:0];
        sswap = int_rsa_i;
        sswap[pos_a_i] = int_rsa_i[pos_b_i];
        sswap[pos_b_i] = int_rsa_i[pos_a_i];
        vswap = vec_rsa_i;
        vswap[int'(epa)*ELEM_SIZE +: ELEM_SIZE] =
            vec_rsa_i[int'(epb)*ELEM_SIZE +: ELEM_SIZE];
        vswap[int'(epb)*ELEM_SIZE +: ELEM_SIZE] =
            vec_rsa_i[int'(epa)*ELEM_SIZE +: ELEM_SIZE];
    end

    // Next-state, beat sequencing and result capture
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        va_d       = va_q;
        vb_d       = vb_q;
        vop_d      = vop_q;
        class_d    = class_q;
        int_res_d  = int_res_q;
        vec_res_d  = vec_res_q;
        flags_d    = flags_q;
        br_taken_d = br_taken_q;
        br_addr_d  = br_addr_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_VBUSY: begin
                    for (int l = 0; l < VECT_LANES; l++) begin
                        int idx;
                        idx = int'(beat_q) * VECT_LANES + l;
                        vec_res_d[idx*ELEM_SIZE +: ELEM_SIZE] =
                            lane_r[l];
                    end
                    beat_d = beat_q + BW'(1);
                    if (beat_q == BW'(BEATS - 1))
                        state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready_i)
                        state_d = ST_IDLE;
                end
                default: state_d = state_q;
            endcase
            if (accept) begin
                state_d    = (op_class_i == CLS_VALU) ?
                             ST_VBUSY : ST_HOLD;
                class_d    = op_class_i;
                br_taken_d = jump_en_i && cond_hit;
                br_addr_d  = jump_addr_i;
                beat_d     = '0;
                unique case (op_class_i)
                    CLS_SALU: begin
                        int_res_d = s_res;
                        flags_d[FLG_N] = s_res[REGI_SIZE-1];
                        flags_d[FLG_Z] = (s_res == '0);
                        flags_d[FLG_C] = s_c;
                        flags_d[FLG_V] = s_v;
                    end
                    CLS_VALU: begin
                        va_d  = vec_rsa_i;
                        vb_d  = vec_rsb_i;
                        vop_d = alu_op_e'(alu_op_i);
                    end
                    CLS_SSWP: int_res_d = sswap;
                    CLS_VSWP: vec_res_d = vswap;
                    default: int_res_d = int_res_q;
                endcase
            end
        end
    end

    // State and result registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            va_q       <= '0;
            vb_q       <= '0;
            vop_q      <= OP_ADD;
            class_q    <= '0;
            int_res_q  <= '0;
            vec_res_q  <= '0;
            flags_q    <= '0;
            br_taken_q <= 1'b0;
            br_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            va_q       <= va_d;
            vb_q       <= vb_d;
            vop_q      <= vop_d;
            class_q    <= class_d;
            int_res_q  <= int_res_d;
            vec_res_q  <= vec_res_d;
            flags_q    <= flags_d;
            br_taken_q <= br_taken_d;
            br_addr_q  <= br_addr_d;
        end
    end

    assign out_valid_o = (state_q == ST_HOLD);
    assign out_class_o = class_q;
    assign int_res_o   = int_res_q;
    assign vec_res_o   = vec_res_q;
    assign flags_o     = flags_q;
    assign br_taken_o  = br_taken_q && out_valid_o;
    assign br_addr_o   = br_addr_q;

endmodule
